// File: rtl/chk_inst_sequencer.sv
// Purpose : fetches instructions from a synchronous ROM, issues them one at a time to the
//           CPU/checker pair, samples the checker's OpDone result and keeps pass/fail scoreboard counts.
// Latency : one instruction every CHK_LAT+3 cycles; OpDone is sampled exactly CHK_LAT cycles after pcEn.
// Backpressure: none. Only one instruction is in flight, and start is ignored while busy.
// Ports:
//   clk, reset (sync, active-low)   start          : run the program from address 0 (idle/done only)
//   imem_addr / imem_data           : ROM address out, data back one cycle later
//   inst / pcEn                     : instruction word and its one-cycle issue strobe
//   OpDone                          : checker verdict, used only in the CHECK cycle
//   busy / done                     : run status
//   pass_cnt / fail_cnt             : saturating scoreboard counters
//   fail_pc / fail_seen             : address of the first failing instruction, plus a sticky flag
module chk_inst_sequencer #(
    parameter int          ADDR_W  = 6,
    parameter int          CHK_LAT = 3,
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       inst,
    output logic              pcEn,
    input  logic              OpDone,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] fail_pc,
    output logic              fail_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // ISSUE accounts for one cycle of latency, so WAIT covers the remaining CHK_LAT-1 cycles.
    localparam logic [3:0]        WAIT_INIT = 4'(CHK_LAT - 1);

    state_t     state;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            imem_addr <= '0;
            inst      <= 32'hFFFF_FFFF;
            pcEn      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_pc   <= '0;
            fail_seen <= 1'b0;
        end else begin
            // pcEn is a single-cycle strobe. It is raised only on the LOAD->ISSUE edge.
            pcEn <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        imem_addr <= '0;
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        fail_pc   <= '0;
                        fail_seen <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (imem_data[31:26] == HALT_OP) begin
                        // The halt word is never issued, and inst keeps the last issued word.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // inst is loaded on entry to ISSUE, so it is valid in the same cycle as pcEn.
                        state <= S_ISSUE;
                        inst  <= imem_data;
                        pcEn  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= (CHK_LAT == 1) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (OpDone) begin
                        if (pass_cnt != CNT_MAX) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end else begin
                        if (fail_cnt != CNT_MAX) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                        if (!fail_seen) begin
                            fail_pc   <= imem_addr;
                            fail_seen <= 1'b1;
                        end
                    end
                    // The last ROM word ends the run. The address never wraps back to 0.
                    if (imem_addr == LAST_ADDR) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        imem_addr <= imem_addr + 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
